i2c_wb_bridge: RTL
==================

# i2c_wb_bridge

Single-transaction bridge between the I2C configuration sequencers (video/VGA setup FSMs) and the Wishbone slave port of the I2C master core. Each `start` pulse carrying a 3-bit register address, write enable and data byte becomes exactly one Wishbone classic single cycle. The bridge then returns read data and a one-cycle `done` pulse. An optional ack timeout protects the sequencers from a hung bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `wb_ack_i` per transaction. Legal range 1..65535. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  8  write data for the transaction.
- `addr`  in  3  core register: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR.
- `start`  in  1  request strobe, sampled only when idle.
- `wren`  in  1  1 = write, 0 = read; sampled with `start`.
- `dout`  out  8  read data; holds its value until the next read completes.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from command acceptance until `done`.
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `wb_adr_o`  out  3  Wishbone address.
- `wb_dat_o`  out  8  Wishbone write data.
- `wb_dat_i`  in  8  Wishbone read data.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_ack_i`  in  1  Wishbone acknowledge.

## Operation
- States: IDLE, BUS, FINISH.
- IDLE:
  - When `start`=1, latch `addr`/`din`/`wren` into `wb_adr_o`/`wb_dat_o`/`wb_we_o`.
  - Assert `wb_cyc_o`=`wb_stb_o`=1, set `busy`=1, clear `err` and the timeout counter, then go to BUS.
- BUS:
  - Hold all Wishbone outputs stable.
  - When `wb_ack_i`=1: capture `wb_dat_i` into `dout` if the transaction is a read (`dout` unchanged on a write), deassert `cyc`/`stb`/`we`, and go to FINISH.
  - With the timeout feature, if the counter reaches `TIMEOUT_CYCLES` with no ack: deassert `cyc`/`stb`, set `err`=1, load `dout`=8'hFF if the transaction is a read, and go to FINISH.
- FINISH:
  - `done`=1 and `busy`=0 for exactly this cycle; go to IDLE.
  - `start` is also sampled here and accepted as if in IDLE, so back-to-back commands lose no cycle.
- `start` while in BUS is ignored: no queueing, no error.
- `wb_ack_i` while `wb_stb_o`=0 is ignored.
- If ack and timeout expiry fall in the same cycle, ack wins: `err` stays 0 and data is captured.
- `wb_adr_o`/`wb_dat_o` hold their last values after completion.
- Bus status polling (TIP) is the caller's job; the bridge only moves bytes.

## Timing
- Reset values: `dout`=0, `done`=0, `busy`=0, `err`=0, all `wb_*_o`=0, state IDLE.
- Reset takes effect immediately mid-transaction: `cyc`/`stb` drop without waiting for the clock, and no `done` is produced.
- Latency:
  - `start` sampled at edge N.
  - `cyc`/`stb`/`busy` high after edge N.
  - Ack sampled at edge N+1+W, where W ≥ 0 is the number of wait cycles before ack.
  - `done` high after edge N+2+W, for one cycle.
- With the registered ack of the I2C core (W=1), `start` to `done` is 3 cycles.
- Timeout path: `done` comes `TIMEOUT_CYCLES`+2 cycles after `start`.
- Timeout counter width is 16 bits and saturates; it never wraps.

## Configuration
- `I2C_BRIDGE_TIMEOUT_EN` defined:
  - Timeout counter and `err` logic are present.
  - A missing ack ends in `done` with `err`=1 and, for a read, `dout`=8'hFF.
- Not defined:
  - BUS waits indefinitely for ack.
  - `err` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Write, ack one cycle after `stb`:
  - Stimulus: `start` with `addr`=0, `din`=8'h55, `wren`=1.
  - Response: `wb_adr_o`=0, `wb_dat_o`=8'h55, `wb_we_o`=1 for 2 cycles; `done` 3 cycles after `start`; `dout` unchanged; `err`=0.
- Read with 4 wait cycles:
  - Stimulus: `addr`=4, `wren`=0, slave returns 8'h02.
  - Response: `dout`=8'h02 at `done`, 6 cycles after `start`; `wb_we_o`=0 throughout.
- Back-to-back:
  - Stimulus: `start` issued again in the `done` cycle (`addr`=3, `din`=8'hEC).
  - Response: `cyc` reasserted the next cycle; `start` pulsed during BUS is ignored, giving exactly two Wishbone cycles.
- Timeout (macro on, `TIMEOUT_CYCLES`=8):
  - Stimulus: read with ack never asserted.
  - Response: `done` 10 cycles after `start`, `err`=1, `dout`=8'hFF, `cyc`=0. The next `start` clears `err`.
- Ack and timeout in the same cycle:
  - Response: `err`=0 and data captured.
- Async reset during BUS:
  - Stimulus: assert `reset` between clock edges.
  - Response: `cyc`/`stb`/`busy` fall immediately; no `done` follows; a fresh transaction completes normally after release.

Source files
------------

// File: rtl/i2c_wb_bridge.sv
// Single-transaction bridge from the I2C setup sequencers to the Wishbone port of the I2C master core.
// Optional ack timeout is compiled in with `define I2C_BRIDGE_TIMEOUT_EN.
module i2c_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic [2:0] addr,
    input  logic       start,
    input  logic       wren,
    output logic [7:0] dout,
    output logic       done,
    output logic       busy,
    output logic       err,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        FINISH
    } state_t;

    state_t state, next_state;
    logic   accept, ack_hit, tmo_hit, tmo_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FINISH accepts a new start exactly like IDLE so back-to-back commands lose no cycle
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ack_hit    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE, FINISH: begin
                next_state = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    next_state = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    ack_hit    = 1'b1;
                    next_state = FINISH;
                end else if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    next_state = FINISH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (accept) begin
                wb_adr_o <= addr;
                wb_dat_o <= din;
                wb_we_o  <= wren;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                busy     <= 1'b1;
            end else if (state == FINISH) begin
                busy <= 1'b0;
            end
            if (ack_hit) begin
                if (!wb_we_o) dout <= wb_dat_i;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
            end
            if (tmo_hit) begin
                if (!wb_we_o) dout <= 8'hFF;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end
        end
    end

`ifdef I2C_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] tmo_cnt;

    // Counter holds the number of completed BUS cycles; it saturates rather than wrapping
    assign tmo_expired = (tmo_cnt >= TMO_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == BUS && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_hit) err <= 1'b1;
        end
    end
`else
    logic [15:0] timeout_unused;

    assign timeout_unused = 16'(TIMEOUT_CYCLES);
    assign tmo_expired    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule
